// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - steps a job through NUM_PHASES phases per job, with per-phase timeout and abort
// Phase enables are active-low one-hot; every output comes straight from a register.
module phase_sequencer #(
  parameter  int NUM_PHASES = 4,
  parameter  int JOB_W      = 8,
  parameter  int TMO_W      = 16,
  localparam int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [JOB_W-1:0]      num_jobs,
  input  logic [TMO_W-1:0]      timeout_lim,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic                  abort,
  output logic [NUM_PHASES-1:0] phase_en_n,
  output logic [PH_W-1:0]       cur_phase,
  output logic [JOB_W-1:0]      jobs_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [PH_W-1:0]       err_phase
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [NUM_PHASES-1:0]   phase_en_n_q;
  logic [PH_W-1:0]         cur_phase_q;
  logic [JOB_W-1:0]        jobs_done_q;
  logic [JOB_W-1:0]        num_jobs_q;
  logic [TMO_W-1:0]        tmo_lim_q;
  logic [TMO_W-1:0]        tmo_cnt_q;
  logic [PH_W-1:0]         err_phase_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;

  logic [PH_W-1:0]         cur_phase_d;
  logic [JOB_W-1:0]        jobs_done_d;
  logic                    last_phase;
  logic                    tmo_hit;
  logic                    cur_done;

  function automatic logic [NUM_PHASES-1:0] enable_n(input logic [PH_W-1:0] idx);
    logic [NUM_PHASES-1:0] one;
    one = {{(NUM_PHASES-1){1'b0}}, 1'b1};
    return ~(one << idx);
  endfunction

  assign cur_phase_d = cur_phase_q + PH_W'(1);
  assign jobs_done_d = jobs_done_q + JOB_W'(1);
  assign last_phase  = (cur_phase_q == PH_W'(NUM_PHASES - 1));
  assign cur_done    = phase_done[cur_phase_q];
  // Expiry fires on the last allowed cycle so a phase gets exactly timeout_lim cycles.
  assign tmo_hit     = (tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_en_n_q <= '1;
      cur_phase_q  <= '0;
      jobs_done_q  <= '0;
      num_jobs_q   <= '0;
      tmo_lim_q    <= '0;
      tmo_cnt_q    <= '0;
      err_phase_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            num_jobs_q  <= num_jobs;
            tmo_lim_q   <= timeout_lim;
            tmo_cnt_q   <= '0;
            cur_phase_q <= '0;
            jobs_done_q <= '0;
            error_q     <= 1'b0;
            if (num_jobs != '0) begin
              state_q      <= ST_RUN;
              busy_q       <= 1'b1;
              phase_en_n_q <= enable_n('0);
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Priority: abort, then phase completion, then timeout.
          if (abort) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            phase_en_n_q <= '1;
          end else if (cur_done) begin
            tmo_cnt_q <= '0;
            if (last_phase) begin
              jobs_done_q <= jobs_done_d;
              if (jobs_done_d < num_jobs_q) begin
                cur_phase_q  <= '0;
                phase_en_n_q <= enable_n('0);
              end else begin
                state_q      <= ST_DONE;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                phase_en_n_q <= '1;
              end
            end else begin
              cur_phase_q  <= cur_phase_d;
              phase_en_n_q <= enable_n(cur_phase_d);
            end
          end else if (tmo_hit) begin
            state_q      <= ST_ERR;
            busy_q       <= 1'b0;
            error_q      <= 1'b1;
            err_phase_q  <= cur_phase_q;
            phase_en_n_q <= '1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phase_en_n = phase_en_n_q;
  assign cur_phase  = cur_phase_q;
  assign jobs_done  = jobs_done_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_phase  = err_phase_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - vector table, directed corner cases and random run against a reference model
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [7:0]  num_jobs;
  logic [15:0] timeout_lim;
  logic [3:0]  phase_done;
  logic [3:0]  phase_en_n;
  logic [1:0]  cur_phase, err_phase;
  logic [7:0]  jobs_done;
  logic        busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  phase_sequencer #(.NUM_PHASES(4), .JOB_W(8), .TMO_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_jobs(num_jobs),
    .timeout_lim(timeout_lim), .phase_done(phase_done), .abort(abort),
    .phase_en_n(phase_en_n), .cur_phase(cur_phase), .jobs_done(jobs_done),
    .busy(busy), .done(done), .error(error), .err_phase(err_phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the sequencer should be doing in plain terms.
  bit m_active, m_pulse, m_err;
  int m_phase, m_errph, m_jobs, m_nj, m_lim, m_dwell;

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_pulse = 0; m_err = 0;
      m_phase = 0; m_errph = 0; m_jobs = 0; m_dwell = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (!m_active) begin
      if (start) begin
        m_err = 0; m_jobs = 0; m_nj = num_jobs; m_lim = timeout_lim;
        m_phase = 0; m_dwell = 0;
        if (m_nj > 0) m_active = 1; else m_pulse = 1;
      end
    end else if (abort) begin
      m_active = 0;
    end else if (phase_done[m_phase]) begin
      m_dwell = 0;
      if (m_phase == 3) begin
        m_jobs++;
        if (m_jobs < m_nj) m_phase = 0;
        else begin m_active = 0; m_pulse = 1; end
      end else begin
        m_phase++;
      end
    end else if (m_lim != 0 && m_dwell + 1 == m_lim) begin
      m_active = 0; m_err = 1; m_errph = m_phase;
    end else begin
      m_dwell++;
    end
  endtask

  task automatic compare_model(input string name);
    logic [3:0]  e_en;
    logic [18:0] a, e;
    e_en = 4'hF;
    if (m_active) e_en = ~(4'b0001 << m_phase);
    e = {e_en, m_active, m_pulse, m_err, 8'(m_jobs),
         m_active ? 2'(m_phase) : 2'b0, m_err ? 2'(m_errph) : 2'b0};
    a = {phase_en_n, busy, done, error, jobs_done,
         m_active ? cur_phase : 2'b0, m_err ? err_phase : 2'b0};
    check(name, 64'(a), 64'(e));
  endtask

  task automatic cyc(input string name = "model");
    model_step();
    @(posedge clk); #1;
    compare_model(name);
  endtask

  typedef struct {
    logic        rst, st, ab;
    logic [7:0]  nj;
    logic [15:0] lim;
    logic [3:0]  pd;
    logic [3:0]  en;
    logic        bsy, dn, er;
    logic [7:0]  jobs;
  } vec_t;

  function automatic vec_t mk(input logic rst, st, ab, input logic [7:0] nj, input logic [15:0] lim,
                              input logic [3:0] pd, en, input logic bsy, dn, er, input logic [7:0] jobs);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.nj = nj; v.lim = lim; v.pd = pd;
    v.en = en; v.bsy = bsy; v.dn = dn; v.er = er; v.jobs = jobs;
    return v;
  endfunction

  vec_t tbl[18];
  int   k, cnt, n_done;
  logic [3:0] exp_en;

  initial begin
    reset = 1; start = 0; abort = 0; num_jobs = 0; timeout_lim = 0; phase_done = 0;

    //            rst st ab nj lim pd    en     bsy dn er jobs
    tbl[0]  = mk(1, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0, 4'hF, 4'hE, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 4'hF, 4'hD, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 4'hF, 4'hB, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 4'hF, 4'h7, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 1, 1, 4'h0, 4'hE, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 4'h0, 4'hF, 0, 0, 1, 0);
    tbl[12] = mk(0, 1, 0, 2, 0, 4'h0, 4'hE, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 4'h1, 4'hF, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 1, 0, 4'h2, 4'hE, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 4'h2, 4'hE, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 4'h1, 4'hD, 1, 0, 0, 0);
    tbl[17] = mk(0 | 1, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; abort = tbl[i].ab;
      num_jobs = tbl[i].nj; timeout_lim = tbl[i].lim; phase_done = tbl[i].pd;
      model_step();
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 64'({phase_en_n, busy, done, error, jobs_done}),
            64'({tbl[i].en, tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].jobs}));
    end
    reset = 0; start = 0; abort = 0; phase_done = 0;

    // Nominal: two jobs, each phase completes on its third enabled cycle.
    start = 1; num_jobs = 2; timeout_lim = 0; cyc("nom_start"); start = 0;
    n_done = 0;
    for (int j = 0; j < 2; j++) begin
      for (int p = 0; p < 4; p++) begin
        exp_en = ~(4'b0001 << p);
        check("nom_en", 64'(phase_en_n), 64'(exp_en));
        cyc("nom"); cyc("nom");
        phase_done = 4'(1 << p);
        cyc("nom");
        phase_done = 0;
        if (done) n_done++;
      end
    end
    check("nom_jobs", 64'(jobs_done), 64'd2);
    check("nom_busy", 64'(busy), 64'd0);
    cyc("nom_after");
    check("nom_done_once", 64'(n_done + int'(done)), 64'd1);

    // Timeout in phase 2, then restart clears the error.
    start = 1; num_jobs = 1; timeout_lim = 5; cyc("tmo_start"); start = 0;
    phase_done = 4'h1; cyc("tmo");
    phase_done = 4'h2; cyc("tmo");
    phase_done = 4'h0;
    cnt = 0; k = 0;
    while (!error && k < 20) begin
      if (phase_en_n == 4'hB) cnt++;
      cyc("tmo_wait"); k++;
    end
    check("tmo_cycles", 64'(cnt), 64'd5);
    check("tmo_err_phase", 64'({error, err_phase, phase_en_n}), 64'({1'b1, 2'd2, 4'hF}));
    start = 1; num_jobs = 1; timeout_lim = 0; cyc("tmo_restart"); start = 0;
    check("tmo_restart", 64'({error, cur_phase, phase_en_n}), 64'({1'b0, 2'd0, 4'hE}));

    // Abort beats a coincident phase_done; then done beats timeout expiry.
    abort = 1; phase_done = 4'h1; cyc("abort"); abort = 0; phase_done = 0;
    check("abort_idle", 64'({busy, done, phase_en_n}), 64'({1'b0, 1'b0, 4'hF}));
    start = 1; num_jobs = 1; timeout_lim = 3; cyc("coin_start"); start = 0;
    cyc("coin"); cyc("coin");
    phase_done = 4'h1; cyc("coin_hit"); phase_done = 0;
    check("coin_adv", 64'({error, phase_en_n}), 64'({1'b0, 4'hD}));
    abort = 1; cyc("coin_abort"); abort = 0;

    // Reset during phase 1 of job 3; then a wrong-phase done at start is ignored.
    start = 1; num_jobs = 4; timeout_lim = 0; phase_done = 4'hF; cyc("mid_start"); start = 0;
    k = 0;
    while (!(jobs_done == 8'd2 && cur_phase == 2'd1) && k < 40) begin cyc("mid"); k++; end
    check("mid_reached", 64'(k < 40), 64'd1);
    reset = 1; cyc("mid_reset"); reset = 0; phase_done = 0;
    check("mid_reset_vals", 64'({phase_en_n, cur_phase, jobs_done, busy, done, error, err_phase}),
          64'({4'hF, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0}));
    start = 1; num_jobs = 1; phase_done = 4'h2; cyc("wrong_start"); start = 0;
    check("wrong_start_en", 64'(phase_en_n), 64'(4'hE));
    cyc("wrong_hold");
    check("wrong_hold_en", 64'(phase_en_n), 64'(4'hE));
    phase_done = 4'h1; cyc("wrong_adv");
    check("wrong_adv_en", 64'(phase_en_n), 64'(4'hD));

    // Randomised traffic against the model.
    reset = 1; cyc("rnd_reset"); reset = 0;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      num_jobs    = 8'($urandom_range(0, 3));
      timeout_lim = 16'($urandom_range(0, 6));
      phase_done  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_PHASES, default 4: number of pipeline phases sequenced (create, initialize, traceback, verdict in the base configuration); legal range 2..16.
REQ-002 Parameter JOB_W, default 8: width of the job counter (sequence pairs per run).
REQ-003 Parameter TMO_W, default 16: width of the per-phase timeout counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin a run; sampled only in IDLE or ERR.
REQ-007 num_jobs  in  JOB_W  jobs per run; latched on accepted start.
REQ-008 timeout_lim  in  TMO_W  max cycles per phase; 0 disables the timeout; latched on accepted start.
REQ-009 phase_done  in  NUM_PHASES  per-phase completion flags, level-sampled.
REQ-010 abort  in  1  cancel the current run.
REQ-011 phase_en_n  out  NUM_PHASES  active-low one-hot phase enable; all ones when no phase is active.
REQ-012 cur_phase  out  clog2(NUM_PHASES)  index of the active phase.
REQ-013 jobs_done  out  JOB_W  completed jobs in the current or last run.
REQ-014 busy  out  1  high in RUN.
REQ-015 done  out  1  one-cycle pulse at run completion.
REQ-016 error  out  1  high in ERR.
REQ-017 err_phase  out  clog2(NUM_PHASES)  phase that timed out; valid while error is high.

Function
REQ-018 The block SHALL implement states IDLE, RUN, DONE and ERR, and all outputs SHALL be registered.
REQ-019 IDLE/ERR + start=1 with num_jobs>0 SHALL go to RUN with cur_phase=0, jobs_done=0, error=0, and phase_en_n[0]=0 on the next cycle.
REQ-020 IDLE/ERR + start=1 with num_jobs=0 SHALL go to DONE (done pulse next cycle) without enabling any phase.
REQ-021 In RUN, exactly one bit of phase_en_n SHALL be 0, the bit at cur_phase.
REQ-022 In RUN, only phase_done[cur_phase] SHALL be considered; all other bits are ignored.
REQ-023 phase_done[cur_phase]=1 with cur_phase<NUM_PHASES-1 SHALL advance cur_phase by 1 on the next cycle: one cycle per phase transition, with no gap cycle.
REQ-024 phase_done[cur_phase]=1 at the last phase SHALL increment jobs_done, then either wrap cur_phase to 0 if jobs_done+1<num_jobs, or go to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle with phase_en_n all ones and busy=0, then go to IDLE; jobs_done SHALL hold until the next accepted start.
REQ-026 The timeout counter SHALL clear on every phase entry and increment each RUN cycle in which phase_done[cur_phase]=0.
REQ-027 If timeout_lim is nonzero and the counter equals timeout_lim-1 with no done, the block SHALL go to ERR next cycle with err_phase=cur_phase, error=1, and phase_en_n all ones.
REQ-028 When phase_done and timeout expiry coincide in the same cycle, done SHALL win.
REQ-029 abort=1 in RUN SHALL go to IDLE next cycle with phase_en_n all ones, no done pulse, and jobs_done held.
REQ-030 abort SHALL have priority over phase_done and timeout; abort in IDLE, DONE or ERR SHALL be ignored.
REQ-031 start in RUN or DONE SHALL be ignored.
REQ-032 ERR SHALL be sticky until an accepted start or reset.
REQ-033 The jobs_done increment SHALL not wrap, because num_jobs is at most 2^JOB_W-1.

Reset
REQ-034 reset=1 SHALL force IDLE on the next edge from any state, including mid-run, with phase_en_n all ones, cur_phase=0, jobs_done=0, busy=0, done=0, error=0, err_phase=0, and the timeout counter at 0.
REQ-035 reset SHALL have priority over all other inputs.

Verification
REQ-036 Nominal run: NUM_PHASES=4, num_jobs=2, timeout_lim=0, each phase_done asserted 3 cycles after its enable -> phase_en_n sequence 1110,1101,1011,0111 twice, jobs_done=2, a single done pulse, busy low after.
REQ-037 Back-to-back dones: phase_done held all ones, num_jobs=1 -> each phase active exactly 1 cycle, done pulse 5 cycles after start.
REQ-038 Timeout: timeout_lim=5, phase 2 never completes -> ERR after 5 cycles in phase 2, err_phase=2, phase_en_n=1111; a subsequent start clears error and restarts at phase 0.
REQ-039 Abort and coincidence: abort in the same cycle as phase_done[cur_phase] -> IDLE, no done pulse; then done coinciding with timeout expiry -> phase advances, no error.
REQ-040 Reset mid-run: reset during phase 1 of job 3 -> all outputs at reset values next cycle; start accepted while phase_done is asserted to a wrong phase -> that done ignored.
REQ-041 Zero jobs: num_jobs=0 -> done pulse with no phase enabled, and jobs_done=0.
